// File: rtl/lvds_eth_framer.sv
// LVDS sampler that packs SAMPLES samples per ping-pong bank and sends each
// full bank as one raw Ethernet frame on an 8-bit AXI-stream toward the MAC.
module lvds_eth_framer #(
    parameter int          CHCOUNT    = 14,
    parameter int          SAMPLE_DIV = 125,
    parameter int          SAMPLES    = 32,
    parameter logic [47:0] DST_MAC    = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC    = 48'h020000000001,
    parameter logic [15:0] ETHTYPE    = 16'h88B5
) (
    input  logic               mac_tx_aclk,
    input  logic               mac_tx_reset,
    input  logic               enable,
    input  logic [CHCOUNT-1:0] usr_lvds_i,
    input  logic [31:0]        firmware_date,
    input  logic [31:0]        firmware_time,
    output logic [7:0]         tx_axis_tdata,
    output logic               tx_axis_tvalid,
    output logic               tx_axis_tlast,
    output logic               tx_axis_tuser,
    input  logic               tx_axis_tready,
    output logic [15:0]        frame_cnt,
    output logic [15:0]        drop_cnt,
    output logic               busy
);

    localparam int BPS       = (CHCOUNT + 7) / 8;
    localparam int HDR_LEN   = 24;
    localparam int MAC_LEN   = 14;
    localparam int FRAME_LEN = HDR_LEN + SAMPLES * BPS;
    localparam int DIV_W     = $clog2(SAMPLE_DIV);
    localparam int IDX_W     = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam int BSEL_W    = (BPS > 1) ? $clog2(BPS) : 1;
    localparam int CNT_W     = $clog2(FRAME_LEN);
    localparam int SAMP_P2   = 1 << IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_INFO, S_PAYLOAD} state_t;

    logic [CHCOUNT-1:0] sync1_q, sync2_q;
    logic [CHCOUNT-1:0] mem [0:2*SAMP_P2-1];

    logic [DIV_W-1:0]   div_q;
    logic               wr_bank_q;
    logic [IDX_W-1:0]   wr_idx_q;
    logic [1:0]         full_q, full_d;
    logic [15:0]        drop_q;
    logic               strobe, wr_take, wr_done, rd_done;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   smp_q, smp_d;
    logic [BSEL_W-1:0]  bsel_q, bsel_d;
    logic               rd_bank_q, rd_bank_d;
    logic [15:0]        seq_q, seq_d;
    logic [31:0]        date_q, date_d, time_q, time_d;
    logic               tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [7:0]         tdata_q, tdata_d;
    logic [15:0]        frame_q, frame_d;
    logic               load;

    logic [HDR_LEN*8-1:0] hdr_vec;
    logic [7:0]           hdr_b [0:HDR_LEN-1];
    logic [CHCOUNT-1:0]   rd_word;
    logic [BPS*8-1:0]     ext;
    logic [7:0]           pay_b [0:BPS-1];

    // Input synchroniser and sample storage carry no reset.
    always_ff @(posedge mac_tx_aclk) begin
        sync1_q <= usr_lvds_i;
        sync2_q <= sync1_q;
        if (wr_take) begin
            mem[{wr_bank_q, wr_idx_q}] <= sync2_q;
        end
        date_q <= date_d;
        time_q <= time_d;
    end

    assign strobe  = enable && (div_q == DIV_W'(SAMPLE_DIV - 1));
    assign wr_take = strobe && !full_q[wr_bank_q];
    assign wr_done = wr_take && (wr_idx_q == IDX_W'(SAMPLES - 1));

    // Writer and reader always touch different banks, so set and clear never collide.
    always_comb begin
        full_d = full_q;
        if (rd_done) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_done) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge mac_tx_aclk) begin
        if (mac_tx_reset) begin
            div_q     <= '0;
            wr_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            full_q    <= '0;
            drop_q    <= '0;
        end else begin
            full_q <= full_d;
            if (!enable) begin
                div_q    <= '0;
                wr_idx_q <= '0;
            end else begin
                div_q <= strobe ? '0 : div_q + DIV_W'(1);
                if (wr_done) begin
                    wr_idx_q  <= '0;
                    wr_bank_q <= ~wr_bank_q;
                end else if (wr_take) begin
                    wr_idx_q <= wr_idx_q + IDX_W'(1);
                end
                if (strobe && full_q[wr_bank_q] && drop_q != 16'hFFFF) begin
                    drop_q <= drop_q + 16'd1;
                end
            end
        end
    end

    // tdata is registered from the byte the counter will point at next, which
    // gives the storage a full clock of read time while keeping one byte per clock.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        smp_d     = smp_q;
        bsel_d    = bsel_q;
        rd_bank_d = rd_bank_q;
        seq_d     = seq_q;
        date_d    = date_q;
        time_d    = time_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tdata_d   = tdata_q;
        frame_d   = frame_q;
        rd_done   = 1'b0;
        load      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = S_HDR;
                    date_d  = firmware_date;
                    time_d  = firmware_time;
                    cnt_d   = '0;
                    smp_d   = '0;
                    bsel_d  = '0;
                end
            end
            default: begin
                if (!tvalid_q) begin
                    tvalid_d = 1'b1;
                    load     = 1'b1;
                end else if (tx_axis_tready) begin
                    if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                        tvalid_d  = 1'b0;
                        tlast_d   = 1'b0;
                        state_d   = S_IDLE;
                        rd_done   = 1'b1;
                        rd_bank_d = ~rd_bank_q;
                        seq_d     = seq_q + 16'd1;
                        frame_d   = frame_q + 16'd1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        load  = 1'b1;
                        if (cnt_q >= CNT_W'(HDR_LEN)) begin
                            if (bsel_q == BSEL_W'(BPS - 1)) begin
                                bsel_d = '0;
                                smp_d  = smp_q + IDX_W'(1);
                            end else begin
                                bsel_d = bsel_q + BSEL_W'(1);
                            end
                        end
                        if (cnt_d < CNT_W'(MAC_LEN)) begin
                            state_d = S_HDR;
                        end else if (cnt_d < CNT_W'(HDR_LEN)) begin
                            state_d = S_INFO;
                        end else begin
                            state_d = S_PAYLOAD;
                        end
                    end
                end
            end
        endcase

        hdr_vec = {DST_MAC, SRC_MAC, ETHTYPE, date_q, time_q, seq_q};
        for (int i = 0; i < HDR_LEN; i++) begin
            hdr_b[i] = hdr_vec[8*(HDR_LEN-1-i) +: 8];
        end
        rd_word = mem[{rd_bank_q, smp_d}];
        ext = '0;
        ext[CHCOUNT-1:0] = rd_word;
        for (int i = 0; i < BPS; i++) begin
            pay_b[i] = ext[8*(BPS-1-i) +: 8];
        end

        if (load) begin
            tdata_d = (cnt_d < CNT_W'(HDR_LEN)) ? hdr_b[cnt_d[4:0]] : pay_b[bsel_d];
            tlast_d = (cnt_d == CNT_W'(FRAME_LEN - 1));
        end
    end

    always_ff @(posedge mac_tx_aclk) begin
        if (mac_tx_reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            smp_q     <= '0;
            bsel_q    <= '0;
            rd_bank_q <= 1'b0;
            seq_q     <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tdata_q   <= '0;
            frame_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            smp_q     <= smp_d;
            bsel_q    <= bsel_d;
            rd_bank_q <= rd_bank_d;
            seq_q     <= seq_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tdata_q   <= tdata_d;
            frame_q   <= frame_d;
        end
    end

    assign tx_axis_tdata  = tdata_q;
    assign tx_axis_tvalid = tvalid_q;
    assign tx_axis_tlast  = tlast_q;
    assign tx_axis_tuser  = 1'b0;
    assign frame_cnt      = frame_q;
    assign drop_cnt       = drop_q;
    assign busy           = (state_q != S_IDLE);

endmodule
